apb_hex_display: RTL and testbench

APB slave peripheral that drives a multiplexed bank of seven-segment digits; it sits on the hex port of the peripheral APB node. It holds a 32-bit display value plus enable, decimal-point and scan-rate registers. It scans the digits with a programmable prescaler, producing active-low segment and anode outputs for the board.

---
 rtl/hex_display_pkg.sv | 23 ++
 rtl/hex_seg_decode.sv | 11 +
 rtl/apb_hex_display.sv | 182 ++++++++++++++++++
 tb/tb_apb_hex_display.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the APB seven-segment display peripheral:
// register word offsets, reset values and the active-low segment table.
package hex_display_pkg;

  localparam logic [2:0] OFF_DATA  = 3'd0;
  localparam logic [2:0] OFF_EN    = 3'd1;
  localparam logic [2:0] OFF_DP    = 3'd2;
  localparam logic [2:0] OFF_DIV   = 3'd3;
  localparam logic [2:0] OFF_BLINK = 3'd4;

  localparam logic [31:0] RST_DATA  = 32'h0000_0000;
  localparam logic [7:0]  RST_EN    = 8'hFF;
  localparam logic [7:0]  RST_DP    = 8'h00;
  localparam logic [7:0]  RST_BLINK = 8'h00;
  localparam logic [6:0]  SEG_OFF   = 7'h7F;

  // Active-low patterns, bit0 = segment a, indexed by hex digit value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational 4-bit to 7-segment decoder, active-low outputs (bit0 = a).
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/apb_hex_display.sv
// APB slave driving a multiplexed bank of active-low seven-segment digits.
// Define HEX_BLINK_EN to add the BLINK register and the 24-bit blink counter.
module apb_hex_display
  import hex_display_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned NUM_DIGITS     = 8,
  parameter logic [15:0] DEFAULT_DIV    = 16'd50000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [APB_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [6:0]                hex_seg_o,
  output logic                      hex_dp_o,
  output logic [NUM_DIGITS-1:0]     hex_an_o
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [2:0]            reg_sel;
  logic                  mapped;
  logic                  wr_en;
  logic                  rd_setup;
  logic [31:0]           rd_val;

  logic [31:0]           data_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic [NUM_DIGITS-1:0] dp_mask_q;
  logic [15:0]           div_q;
  logic [15:0]           cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           prdata_q;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  hex_dp_q, hex_dp_d;

  logic [7:0]            en_ext;
  logic [7:0]            dp_ext;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic                  show;

  logic                  unused_addr;
  assign unused_addr = ^{paddr_i[APB_ADDR_WIDTH-1:5], paddr_i[1:0]};

  assign reg_sel  = paddr_i[4:2];
  assign wr_en    = psel_i & penable_i & pwrite_i & mapped;
  assign rd_setup = psel_i & ~penable_i & ~pwrite_i;

`ifdef HEX_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_q;
  logic [23:0]           blink_cnt_q;
  logic [7:0]            blink_ext;
  assign blink_ext = 8'(blink_q);
`endif

  // Address decode doubles as read mux; unmapped offsets read 0.
  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    case (reg_sel)
      OFF_DATA: begin
        mapped = 1'b1;
        rd_val = data_q;
      end
      OFF_EN: begin
        mapped = 1'b1;
        rd_val[NUM_DIGITS-1:0] = en_q;
      end
      OFF_DP: begin
        mapped = 1'b1;
        rd_val[NUM_DIGITS-1:0] = dp_mask_q;
      end
      OFF_DIV: begin
        mapped = 1'b1;
        rd_val[15:0] = div_q;
      end
`ifdef HEX_BLINK_EN
      OFF_BLINK: begin
        mapped = 1'b1;
        rd_val[NUM_DIGITS-1:0] = blink_q;
      end
`endif
      default: ;
    endcase
  end

  // Terminal count uses >= so a DIV written below cnt advances next cycle.
  always_comb begin
    if (cnt_q >= div_q) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end
  end

  assign en_ext = 8'(en_q);
  assign dp_ext = 8'(dp_mask_q);
  assign nibble = data_q[{idx_q, 2'b00} +: 4];

`ifdef HEX_BLINK_EN
  assign show = en_ext[idx_q] & ~(blink_cnt_q[23] & blink_ext[idx_q]);
`else
  assign show = en_ext[idx_q];
`endif

  hex_seg_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    an_d     = '1;
    seg_d    = SEG_OFF;
    hex_dp_d = 1'b1;
    if (show) begin
      an_d     = ~NUM_DIGITS'(8'd1 << idx_q);
      seg_d    = seg_dec;
      hex_dp_d = ~dp_ext[idx_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= RST_DATA;
      en_q      <= RST_EN[NUM_DIGITS-1:0];
      dp_mask_q <= RST_DP[NUM_DIGITS-1:0];
      div_q     <= DEFAULT_DIV;
      cnt_q     <= '0;
      idx_q     <= '0;
      prdata_q  <= '0;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      hex_dp_q  <= 1'b1;
`ifdef HEX_BLINK_EN
      blink_q     <= RST_BLINK[NUM_DIGITS-1:0];
      blink_cnt_q <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      hex_dp_q <= hex_dp_d;
      if (rd_setup) prdata_q <= rd_val;
      if (wr_en) begin
        case (reg_sel)
          OFF_DATA: data_q    <= pwdata_i[31:0];
          OFF_EN:   en_q      <= pwdata_i[NUM_DIGITS-1:0];
          OFF_DP:   dp_mask_q <= pwdata_i[NUM_DIGITS-1:0];
          OFF_DIV:  div_q     <= pwdata_i[15:0];
`ifdef HEX_BLINK_EN
          OFF_BLINK: blink_q  <= pwdata_i[NUM_DIGITS-1:0];
`endif
          default: ;
        endcase
      end
`ifdef HEX_BLINK_EN
      blink_cnt_q <= blink_cnt_q + 24'd1;
`endif
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = 1'b1;
  assign pslverr_o = psel_i & penable_i & ~mapped;
  assign hex_an_o  = an_q;
  assign hex_seg_o = seg_q;
  assign hex_dp_o  = hex_dp_q;

endmodule

// File: tb/tb_apb_hex_display.sv
// Directed self-checking bench for apb_hex_display (default parameters).
module tb_apb_hex_display;

  localparam logic [6:0] SEG_EXP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [6:0]  hex_seg;
  logic        hex_dp;
  logic [7:0]  hex_an;

  int checks = 0;
  int errors = 0;

  apb_hex_display dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .pwrite_i  (pwrite),
    .psel_i    (psel),
    .penable_i (penable),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .hex_seg_o (hex_seg),
    .hex_dp_o  (hex_dp),
    .hex_an_o  (hex_an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    tick();
    paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1 err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    tick();
    paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_rst [4];
    exp_rst = '{32'h0, 32'hFF, 32'h0, 32'd50000};
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (hex_an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected %h", hex_an, 8'hFF); end
    checks++; if (hex_seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected %h", hex_seg, 7'h7F); end
    checks++; if (hex_dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", hex_dp); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b expected 0", pslverr); end
    checks++; if (pready !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b expected 1", pready); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apb_read(32'(i * 4), rd, err);
      checks++; if (rd !== exp_rst[i]) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", i, rd, exp_rst[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_reg%0d_err: got %b expected 0", i, err); end
    end
  endtask

  task automatic test_scan_div0();
    logic err;
    bit   found;
    apb_write(32'h00, 32'h7654_3210, err);
    apb_write(32'h0C, 32'h0, err);
    tick();
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (hex_an === 8'hFE) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL div0_sync: got %h expected FE within 40 cycles", hex_an); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] one;
      logic [7:0] exp_an;
      one = 8'd1;
      exp_an = ~(one << i);
      checks++; if (hex_an !== exp_an) begin errors++; $display("FAIL div0_an%0d: got %h expected %h", i, hex_an, exp_an); end
      checks++; if (hex_seg !== SEG_EXP[i]) begin errors++; $display("FAIL div0_seg%0d: got %h expected %h", i, hex_seg, SEG_EXP[i]); end
      checks++; if (hex_dp !== 1'b1) begin errors++; $display("FAIL div0_dp%0d: got %b expected 1", i, hex_dp); end
      tick();
    end
  endtask

  task automatic test_enable_div3();
    logic       err;
    logic [7:0] prev;
    logic [7:0] en_v;
    logic [7:0] dp_v;
    bit         found;
    en_v = 8'h05;
    dp_v = 8'h04;
    apb_write(32'h04, 32'h0000_0005, err);
    apb_write(32'h08, 32'hFFFF_FF04, err);
    apb_write(32'h0C, 32'd3, err);
    prev = hex_an;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      tick();
      if (prev !== 8'hFE && hex_an === 8'hFE) found = 1'b1;
      prev = hex_an;
    end
    checks++; if (!found) begin errors++; $display("FAIL div3_sync: got %h expected entry into FE within 100 cycles", hex_an); end
    for (int c = 0; c < 32; c++) begin
      int         k;
      logic [7:0] one;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      k = c / 4;
      one = 8'd1;
      exp_an  = en_v[k] ? ~(one << k) : 8'hFF;
      exp_seg = en_v[k] ? SEG_EXP[k] : 7'h7F;
      exp_dp  = en_v[k] ? ~dp_v[k] : 1'b1;
      checks++; if (hex_an !== exp_an) begin errors++; $display("FAIL div3_an c%0d: got %h expected %h", c, hex_an, exp_an); end
      checks++; if (hex_seg !== exp_seg) begin errors++; $display("FAIL div3_seg c%0d: got %h expected %h", c, hex_seg, exp_seg); end
      checks++; if (hex_dp !== exp_dp) begin errors++; $display("FAIL div3_dp c%0d: got %b expected %b", c, hex_dp, exp_dp); end
      tick();
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic        err;
    logic [31:0] bad_addr [3];
    logic [31:0] exp_regs [4];
    bad_addr = '{32'h14, 32'h18, 32'h1C};
    exp_regs = '{32'h7654_3210, 32'h05, 32'h04, 32'd3};
    apb_read(32'h00, rd, err);
    checks++; if (rd !== 32'h7654_3210) begin errors++; $display("FAIL data_read: got %h expected 76543210", rd); end
    for (int i = 0; i < 3; i++) begin
      apb_read(bad_addr[i], rd, err);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL unmapped_rd_err %h: got %b expected 1", bad_addr[i], err); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd_data %h: got %h expected 0", bad_addr[i], rd); end
    end
    apb_read(32'h0C, rd, err);
    apb_write(32'h14, 32'hFFFF_FFFF, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unmapped_wr_err: got %b expected 1", err); end
    checks++; if (prdata !== 32'd3) begin errors++; $display("FAIL prdata_hold: got %h expected 3", prdata); end
    for (int i = 0; i < 4; i++) begin
      apb_read(32'(i * 4), rd, err);
      checks++; if (rd !== exp_regs[i]) begin errors++; $display("FAIL after_unmapped_reg%0d: got %h expected %h", i, rd, exp_regs[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL after_unmapped_err%0d: got %b expected 0", i, err); end
    end
  endtask

  task automatic test_blink_reg();
    logic [31:0] rd;
    logic        err;
`ifdef HEX_BLINK_EN
    apb_write(32'h10, 32'hFFFF_FF01, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL blink_wr_err: got %b expected 0", err); end
    apb_read(32'h10, rd, err);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL blink_rd: got %h expected 1", rd); end
    apb_write(32'h10, 32'h0, err);
`else
    apb_read(32'h10, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL blink_rd_err: got %b expected 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL blink_rd_data: got %h expected 0", rd); end
    apb_write(32'h10, 32'hFF, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL blink_wr_err: got %b expected 1", err); end
`endif
  endtask

  task automatic test_div_shrink();
    logic       err;
    logic [7:0] start;
    int         n;
    apb_write(32'h04, 32'hFF, err);
    apb_write(32'h0C, 32'd1000, err);
    start = hex_an;
    n = 0;
    while (hex_an === start && n < 1100) begin
      tick();
      n++;
    end
    checks++; if (hex_an === start) begin errors++; $display("FAIL shrink_sync: got no anode change in %0d cycles, expected one", n); end
    repeat (800) tick();
    apb_write(32'h0C, 32'd10, err);
    for (int s = 0; s < 3; s++) begin
      int exp_n;
      exp_n = (s == 0) ? 2 : 11;
      start = hex_an;
      n = 0;
      while (hex_an === start && n < 50) begin
        tick();
        n++;
      end
      checks++; if (n != exp_n) begin errors++; $display("FAIL shrink_step%0d: got %0d cycles expected %0d", s, n, exp_n); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    tick();
    paddr = 32'h00; pwdata = 32'hDEAD_BEEF; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    checks++; if (hex_an !== 8'hFF) begin errors++; $display("FAIL mid_rst_an: got %h expected FF", hex_an); end
    checks++; if (hex_seg !== 7'h7F) begin errors++; $display("FAIL mid_rst_seg: got %h expected 7F", hex_seg); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL mid_rst_prdata: got %h expected 0", prdata); end
    apb_read(32'h00, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", rd); end
    apb_read(32'h0C, rd, err);
    checks++; if (rd !== 32'd50000) begin errors++; $display("FAIL mid_rst_div: got %h expected %h", rd, 32'd50000); end
    apb_write(32'h00, 32'h0000_ABCD, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL post_rst_wr_err: got %b expected 0", err); end
    apb_read(32'h00, rd, err);
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL post_rst_data: got %h expected 0000abcd", rd); end
  endtask

  initial begin
    test_reset();
    test_scan_div0();
    test_enable_div3();
    test_unmapped();
    test_blink_reg();
    test_div_shrink();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
